// File: rtl/data_mem_pkg.sv
// Shared encodings, request payload and lane helpers for the byte-lane data memory.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [1:0]  off;
    logic [31:0] wdata;
    logic        mis;
    logic        rng;
  } acc_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = (off != 2'b00);
      SZ_RSVD: misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  endfunction

  // Replicate right-aligned store data onto every lane; the byte-enable picks the target.
  function automatic logic [31:0] store_align(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: store_align = {4{data[7:0]}};
      SZ_HALF: store_align = {2{data[15:0]}};
      default: store_align = data;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sign_ext);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = 16'(word >> {off[1], 4'b0000});
    case (size)
      SZ_BYTE: load_extract = {{24{sign_ext & b[7]}}, b};
      SZ_HALF: load_extract = {{16{sign_ext & h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x 32 storage, no reset: one byte-enabled synchronous write port, one async read port.
module data_mem_array #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned TEST_WORD = 0,
  localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata,
  output logic [15:0]      test_value
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata      = mem[raddr];
  assign test_value = mem[IDX_W'(TEST_WORD)][15:0];

endmodule

// File: rtl/data_mem_bytelane.sv
// Data memory with sized loads/stores, req/ready handshake, wait states and a post-reset clear sweep.
module data_mem_bytelane
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned TEST_WORD   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              write_enable,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] add,
  input  logic [31:0]       write_data,
  output logic              ready,
  output logic [31:0]       read_data,
  output logic              misalign_err,
  output logic              range_err,
  output logic              init_done,
  output logic [15:0]       test_value
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [3:0]       wait_q, wait_d;
  acc_t             cap_q, cap_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ready_q, ready_d;
  logic [31:0]      read_data_q, read_data_d;
  logic             misalign_err_q, misalign_err_d;
  logic             range_err_q, range_err_d;
  logic             init_done_q, init_done_d;

  logic             mem_we_c;
  logic [3:0]       mem_be_c;
  logic [IDX_W-1:0] mem_waddr_c;
  logic [31:0]      mem_wdata_c;
  logic [31:0]      mem_rdata_c;
  logic [ADDR_W-1:0] word_idx_c;
  logic             range_c;

  assign word_idx_c = {2'b00, add[ADDR_W-1:2]};
  assign range_c    = (word_idx_c >= ADDR_W'(DEPTH));

  data_mem_array #(
    .DEPTH     (DEPTH),
    .TEST_WORD (TEST_WORD)
  ) u_array (
    .clk        (clk),
    .we         (mem_we_c),
    .be         (mem_be_c),
    .waddr      (mem_waddr_c),
    .wdata      (mem_wdata_c),
    .raddr      (idx_q),
    .rdata      (mem_rdata_c),
    .test_value (test_value)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_INIT;
      sweep_q        <= '0;
      wait_q         <= '0;
      cap_q          <= '0;
      idx_q          <= '0;
      ready_q        <= 1'b0;
      read_data_q    <= '0;
      misalign_err_q <= 1'b0;
      range_err_q    <= 1'b0;
      init_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sweep_q        <= sweep_d;
      wait_q         <= wait_d;
      cap_q          <= cap_d;
      idx_q          <= idx_d;
      ready_q        <= ready_d;
      read_data_q    <= read_data_d;
      misalign_err_q <= misalign_err_d;
      range_err_q    <= range_err_d;
      init_done_q    <= init_done_d;
    end
  end

  // Next-state, capture, completion and array write-port control.
  always_comb begin
    state_d        = state_q;
    sweep_d        = sweep_q;
    wait_d         = wait_q;
    cap_d          = cap_q;
    idx_d          = idx_q;
    ready_d        = 1'b0;
    read_data_d    = read_data_q;
    misalign_err_d = 1'b0;
    range_err_d    = 1'b0;
    init_done_d    = init_done_q;
    mem_we_c       = 1'b0;
    mem_be_c       = 4'b0000;
    mem_waddr_c    = sweep_q;
    mem_wdata_c    = '0;

    case (state_q)
      ST_INIT: begin
        mem_we_c = 1'b1;
        mem_be_c = 4'b1111;
        if (sweep_q == IDX_W'(DEPTH - 1)) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (req) begin
          cap_d = '{we: write_enable, size: size, sign_ext: sign_ext, off: add[1:0],
                    wdata: write_data, mis: misaligned(size, add[1:0]), rng: range_c};
          idx_d   = add[IDX_W+1:2];
          wait_d  = 4'(WAIT_STATES);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          if (cap_q.mis || cap_q.rng) begin
            misalign_err_d = cap_q.mis;
            range_err_d    = cap_q.rng;
            read_data_d    = '0;
          end else if (cap_q.we) begin
            mem_we_c    = 1'b1;
            mem_be_c    = lane_mask(cap_q.size, cap_q.off);
            mem_waddr_c = idx_q;
            mem_wdata_c = store_align(cap_q.size, cap_q.wdata);
          end else begin
            read_data_d = load_extract(mem_rdata_c, cap_q.size, cap_q.off, cap_q.sign_ext);
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign ready        = ready_q;
  assign read_data    = read_data_q;
  assign misalign_err = misalign_err_q;
  assign range_err    = range_err_q;
  assign init_done    = init_done_q;

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Randomised self-checking bench for data_mem_bytelane against a word-array reference model.
module tb_data_mem_bytelane;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WS    = 3;
  localparam int unsigned TW    = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        write_enable;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] add;
  logic [31:0] write_data;
  logic        ready;
  logic [31:0] read_data;
  logic        misalign_err;
  logic        range_err;
  logic        init_done;
  logic [15:0] test_value;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  data_mem_bytelane #(
    .DEPTH       (DEPTH),
    .ADDR_W      (32),
    .WAIT_STATES (WS),
    .TEST_WORD   (TW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .write_enable (write_enable),
    .size         (size),
    .sign_ext     (sign_ext),
    .add          (add),
    .write_data   (write_data),
    .ready        (ready),
    .read_data    (read_data),
    .misalign_err (misalign_err),
    .range_err    (range_err),
    .init_done    (init_done),
    .test_value   (test_value)
  );

  function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [1:0] sz,
                                           input logic [1:0] off, input logic se);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (word >> (8 * off)) & 32'hFF;
      if (se && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (word >> (16 * off[1])) & 32'hFFFF;
      if (se && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] sz,
                                        input logic [1:0] off, input logic [31:0] wd);
    int sh;
    if (sz == 2'b00) begin
      sh = 8 * off;
      return (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end else if (sz == 2'b01) begin
      sh = 16 * off[1];
      return (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      tests_run++;
      if (ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_ready_in_init: got %b expected 0", tag, ready);
      end
    end while (init_done !== 1'b1 && n < 40);
    req = 1'b0;
    tests_run++;
    if (n != DEPTH) begin
      tests_failed++;
      $display("FAIL %s_sweep_len: got %0d edges expected %0d", tag, n, DEPTH);
    end
    tests_run++;
    if (test_value !== 16'h0) begin
      tests_failed++;
      $display("FAIL %s_test_value: got %h expected 0000", tag, test_value);
    end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
  endtask

  task automatic do_access(input logic w, input logic [1:0] sz, input logic se,
                           input logic [31:0] a, input logic [31:0] wd);
    logic        mis, rng, chk_rd;
    logic [31:0] exp_rd;
    int unsigned widx;
    int          n;
    mis  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    widx = a >> 2;
    rng  = (widx >= DEPTH);
    chk_rd = mis || rng || !w;
    exp_rd = last_rd;
    if (mis || rng) exp_rd = 32'h0;
    else if (!w) exp_rd = exp_load(mem_m[widx], sz, a[1:0], se);

    @(negedge clk);
    req = 1'b1; write_enable = w; size = sz; sign_ext = se; add = a; write_data = wd;
    @(posedge clk); #1;
    req = 1'b0; write_enable = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
    add = $urandom; write_data = $urandom;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ready !== 1'b1 && n < 20);
    tests_run++;
    if (n != WS + 1) begin
      tests_failed++;
      $display("FAIL latency: got %0d edges expected %0d (addr %h)", n, WS + 1, a);
    end
    if (!mis && !rng && w) mem_m[widx] = merge(mem_m[widx], sz, a[1:0], wd);
    if (chk_rd) begin
      last_rd = exp_rd;
      tests_run++;
      if (read_data !== exp_rd) begin
        tests_failed++;
        $display("FAIL read_data: got %h expected %h (we %b sz %b se %b addr %h)",
                 read_data, exp_rd, w, sz, se, a);
      end
    end
    tests_run++;
    if (misalign_err !== mis || range_err !== rng) begin
      tests_failed++;
      $display("FAIL err_flags: got mis %b rng %b expected mis %b rng %b (sz %b addr %h)",
               misalign_err, range_err, mis, rng, sz, a);
    end
    tests_run++;
    if (test_value !== mem_m[TW][15:0]) begin
      tests_failed++;
      $display("FAIL test_value: got %h expected %h", test_value, mem_m[TW][15:0]);
    end
    @(posedge clk); #1;
    tests_run++;
    if (ready !== 1'b0 || misalign_err !== 1'b0 || range_err !== 1'b0 || read_data !== last_rd) begin
      tests_failed++;
      $display("FAIL after_ready: got rdy %b mis %b rng %b rd %h expected 0 0 0 %h",
               ready, misalign_err, range_err, read_data, last_rd);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 1'b0; write_enable = 1'b0; size = 2'b10; sign_ext = 1'b0;
    add = 32'h0; write_data = 32'h0; last_rd = 32'h0;
    @(posedge clk); #1;
    tests_run++;
    if (ready !== 1'b0 || read_data !== 32'h0 || misalign_err !== 1'b0 ||
        range_err !== 1'b0 || init_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rdy %b rd %h mis %b rng %b done %b expected all 0",
               ready, read_data, misalign_err, range_err, init_done);
    end
    @(negedge clk);
    reset = 1'b0;
    req = 1'b1; write_enable = 1'b1; add = 32'h4; write_data = 32'hFFFF_FFFF;
    wait_init("reset");
  endtask

  task automatic test_load_store;
    do_access(1'b1, 2'b10, 1'b0, 32'h4, 32'hDEAD_BEEF);
    do_access(1'b0, 2'b00, 1'b1, 32'h5, 32'h0);
    do_access(1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
    do_access(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_1234);
    do_access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    do_access(1'b0, 2'b01, 1'b1, 32'h4, 32'h0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp1;
    exp1 = mem_m[1];
    @(negedge clk);
    req = 1'b1; write_enable = 1'b0; size = 2'b10; sign_ext = 1'b0; add = 32'h4;
    @(posedge clk); #1;
    write_enable = 1'b1; add = 32'h8; write_data = 32'hCAFE_F00D;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 9) req = 1'b0;
      tests_run++;
      if (ready !== ((k == 4 || k == 9) ? 1'b1 : 1'b0)) begin
        tests_failed++;
        $display("FAIL b2b_ready_edge%0d: got %b expected %b", k, ready, (k == 4 || k == 9));
      end
      if (k == 4) begin
        tests_run++;
        if (read_data !== exp1) begin
          tests_failed++;
          $display("FAIL b2b_read_data: got %h expected %h", read_data, exp1);
        end
        last_rd = exp1;
      end
    end
    mem_m[2] = 32'hCAFE_F00D;
    do_access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
  endtask

  task automatic test_errors;
    do_access(1'b0, 2'b10, 1'b0, 32'h2, 32'h0);
    do_access(1'b1, 2'b10, 1'b0, DEPTH * 4, 32'h1111_1111);
    do_access(1'b1, 2'b01, 1'b0, 32'h5, 32'h2222_2222);
    do_access(1'b0, 2'b11, 1'b0, 32'h4, 32'h0);
    do_access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    do_access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 150; i++) begin
      do_access(1'($urandom), 2'($urandom), 1'($urandom),
                32'($urandom_range(0, DEPTH * 4 + 7)), $urandom);
    end
  endtask

  task automatic test_reset_busy;
    do_access(1'b1, 2'b10, 1'b0, 32'h4, 32'h0);
    @(negedge clk);
    req = 1'b1; write_enable = 1'b1; size = 2'b10; add = 32'h4; write_data = 32'h55;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (init_done !== 1'b0 || ready !== 1'b0 || test_value !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_busy: got done %b rdy %b tv %h expected 0 0 0000",
               init_done, ready, test_value);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_rd = 32'h0;
    wait_init("reset_busy");
    do_access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
  endtask

  initial begin
    test_reset;
    test_load_store;
    test_back_to_back;
    test_errors;
    test_random;
    test_reset_busy;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
